vga_timing_gen: RTL and testbench

Parametrised raster timing generator, successor to the fixed 640x480 sync unit. Produces hsync/vsync, video_on and pixel coordinates for any mode from porch/sync parameters, with programmable sync polarity, a system-clock-to-pixel divider, a run/freeze enable, and line/frame start strobes. Sits between the board clock and the graphics generator inside the display top. All position outputs are mutually aligned.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_pixel_tick.sv | 38 +++
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the raster timing generator: 640x480@60 defaults,
// axis-total helpers and the sync polarity encoding.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_CW       = 10;

    // Value of the sync line while the sync pulse is active.
    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// System-clock-to-pixel divider: pixel_tick is high for one clk every CLK_DIV
// enabled clks; the count freezes while enable is low.
module vga_pixel_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic pixel_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    // Combinational from the register so the tick lands in the cycle the count hits DIV_LAST.
    assign pixel_tick = enable && (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (pixel_tick) begin
            div_cnt_d = '0;
        end else if (enable) begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, sync decode and strobes.
// Optional 16-bit frame counter port when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = POL_ACTIVE_LOW,
    parameter logic VS_POL   = POL_ACTIVE_LOW,
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          pixel_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic          tick;
    logic [CW-1:0] pixel_x_q, pixel_x_d;
    logic [CW-1:0] pixel_y_q, pixel_y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]   frame_cnt_q, frame_cnt_d;
`endif

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pixel_tick (tick)
    );

    // Decode from the next position so every registered output matches the counters.
    always_comb begin
        pixel_x_d = pixel_x_q;
        pixel_y_d = pixel_y_q;
        if (tick) begin
            if (pixel_x_q == X_LAST) begin
                pixel_x_d = '0;
                pixel_y_d = (pixel_y_q == Y_LAST) ? '0 : pixel_y_q + CW'(1);
            end else begin
                pixel_x_d = pixel_x_q + CW'(1);
            end
        end
        hsync_d       = ((pixel_x_d >= HS_START) && (pixel_x_d <= HS_END)) ? HS_POL : ~HS_POL;
        vsync_d       = ((pixel_y_d >= VS_START) && (pixel_y_d <= VS_END)) ? VS_POL : ~VS_POL;
        video_on_d    = (pixel_x_d < X_ACT) && (pixel_y_d < Y_ACT);
        line_start_d  = tick && (pixel_x_d == '0);
        frame_start_d = line_start_d && (pixel_y_d == '0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        frame_cnt_d   = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_x_q     <= X_LAST;
            pixel_y_q     <= Y_LAST;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            frame_cnt_q   <= 16'd0;
`endif
        end else begin
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign pixel_tick  = tick;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
    assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance (CLK_DIV=2) plus a tiny mode
// instance (CLK_DIV=1, H=4/1/2/1, V=2/1/1/1, HS_POL=1) sharing clk and reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic en_d;
    logic en_s;

    always #5 clk = ~clk;

    logic       d_tick, d_hs, d_vs, d_von, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_tick, s_hs, s_vs, s_von, s_ls, s_fs;
    logic [9:0] s_x, s_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] d_fc, s_fc;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    vga_timing_gen u_dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (en_d),
        .pixel_tick  (d_tick),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .video_on    (d_von),
        .pixel_x     (d_x),
        .pixel_y     (d_y),
        .line_start  (d_ls),
        .frame_start (d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (d_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b0), .CLK_DIV (1), .CW (10)
    ) u_small (
        .clk         (clk),
        .reset       (reset),
        .enable      (en_s),
        .pixel_tick  (s_tick),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .video_on    (s_von),
        .pixel_x     (s_x),
        .pixel_y     (s_y),
        .line_start  (s_ls),
        .frame_start (s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (s_fc)
`endif
    );

    task automatic test_reset();
        reset = 1'b0;
        en_d  = 1'b1;
        en_s  = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (d_x !== 10'd799) begin failures++; $display("FAIL rst_x got=%0d exp=799", d_x); end
        checks++; if (d_y !== 10'd524) begin failures++; $display("FAIL rst_y got=%0d exp=524", d_y); end
        checks++; if ({d_hs, d_vs} !== 2'b11) begin failures++; $display("FAIL rst_sync got=%b exp=11", {d_hs, d_vs}); end
        checks++; if ({d_von, d_ls, d_fs, d_tick} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {d_von, d_ls, d_fs, d_tick}); end
        checks++; if (s_x !== 10'd7 || s_y !== 10'd4) begin failures++; $display("FAIL rst_small_pos got=%0d,%0d exp=7,4", s_x, s_y); end
        checks++; if ({s_hs, s_vs, s_von, s_ls, s_fs} !== 5'b01000) begin failures++; $display("FAIL rst_small_flags got=%b exp=01000", {s_hs, s_vs, s_von, s_ls, s_fs}); end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++; if (d_fc !== 16'd0) begin failures++; $display("FAIL rst_frame_cnt got=%0d exp=0", d_fc); end
`endif
    endtask

    task automatic test_startup();
        reset = 1'b1;  // cycle 0 begins
        #1;
        checks++; if (d_tick !== 1'b0) begin failures++; $display("FAIL start_c0_tick got=%b exp=0", d_tick); end
        @(negedge clk);  // cycle 1
        checks++; if (d_tick !== 1'b1 || d_x !== 10'd799) begin failures++; $display("FAIL start_c1 got tick=%b x=%0d exp tick=1 x=799", d_tick, d_x); end
        @(negedge clk);  // cycle 2
        checks++; if (d_tick !== 1'b0 || d_x !== 10'd0 || d_y !== 10'd0) begin failures++; $display("FAIL start_c2_pos got tick=%b x=%0d y=%0d exp 0,0,0", d_tick, d_x, d_y); end
        checks++; if ({d_von, d_ls, d_fs, d_hs, d_vs} !== 5'b11111) begin failures++; $display("FAIL start_c2_flags got=%b exp=11111", {d_von, d_ls, d_fs, d_hs, d_vs}); end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++; if (d_fc !== 16'd1) begin failures++; $display("FAIL start_frame_cnt got=%0d exp=1", d_fc); end
`endif
        @(negedge clk);  // cycle 3
        checks++; if (d_tick !== 1'b1 || d_ls !== 1'b0 || d_fs !== 1'b0 || d_x !== 10'd0) begin failures++; $display("FAIL start_c3 got tick=%b ls=%b fs=%b x=%0d exp 1,0,0,0", d_tick, d_ls, d_fs, d_x); end
    endtask

    task automatic test_line();
        int bad_pos = 0, bad_hs = 0, bad_von = 0, bad_strobe = 0, low_cnt = 0;
        logic hs_exp;
        for (int e = 0; e < 800; e++) begin
            if (d_tick !== 1'b1 || d_x !== 10'(e) || d_y !== 10'd0) bad_pos++;
            hs_exp = (e >= 656 && e <= 751) ? 1'b0 : 1'b1;
            if (d_hs !== hs_exp) bad_hs++;
            if (d_hs === 1'b0) low_cnt++;
            if (d_von !== (e < 640)) bad_von++;
            if (d_ls !== 1'b0 || d_fs !== 1'b0) bad_strobe++;
            @(negedge clk);
            if (d_tick !== 1'b0 || d_x !== 10'((e + 1) % 800) || d_y !== ((e == 799) ? 10'd1 : 10'd0)) bad_pos++;
            if (d_ls !== (e == 799) || d_fs !== 1'b0) bad_strobe++;
            @(negedge clk);
        end
        checks++; if (bad_pos !== 0) begin failures++; $display("FAIL line_pos bad_samples=%0d exp=0", bad_pos); end
        checks++; if (bad_hs !== 0) begin failures++; $display("FAIL line_hsync bad_samples=%0d exp=0", bad_hs); end
        checks++; if (low_cnt !== 96) begin failures++; $display("FAIL line_hsync_width got=%0d exp=96", low_cnt); end
        checks++; if (bad_von !== 0) begin failures++; $display("FAIL line_video_on bad_samples=%0d exp=0", bad_von); end
        checks++; if (bad_strobe !== 0) begin failures++; $display("FAIL line_strobes bad_samples=%0d exp=0", bad_strobe); end
    endtask

    task automatic test_freeze();
        int bad = 0;
        repeat (600) @(negedge clk);
        checks++; if (d_tick !== 1'b1 || d_x !== 10'd300 || d_y !== 10'd1) begin failures++; $display("FAIL frz_pre got tick=%b x=%0d y=%0d exp 1,300,1", d_tick, d_x, d_y); end
        en_d = 1'b0;  // falls in a would-be tick cycle
        #1;
        checks++; if (d_tick !== 1'b0) begin failures++; $display("FAIL frz_suppress got=%b exp=0", d_tick); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d_tick !== 1'b0 || d_x !== 10'd300 || d_y !== 10'd1 || d_ls !== 1'b0 || d_von !== 1'b1 || d_hs !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL frz_hold bad_samples=%0d exp=0", bad); end
        en_d = 1'b1;
        #1;
        checks++; if (d_tick !== 1'b1 || d_x !== 10'd300) begin failures++; $display("FAIL frz_resume got tick=%b x=%0d exp 1,300", d_tick, d_x); end
        @(negedge clk);
        checks++; if (d_tick !== 1'b0 || d_x !== 10'd301) begin failures++; $display("FAIL frz_step got tick=%b x=%0d exp 0,301", d_tick, d_x); end
        @(negedge clk);
        checks++; if (d_tick !== 1'b1 || d_x !== 10'd301) begin failures++; $display("FAIL frz_spacing got tick=%b x=%0d exp 1,301", d_tick, d_x); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checks++; if (d_x !== 10'd799 || d_y !== 10'd524) begin failures++; $display("FAIL mrst_pos got=%0d,%0d exp=799,524", d_x, d_y); end
        checks++; if ({d_hs, d_vs, d_von, d_tick} !== 4'b1100) begin failures++; $display("FAIL mrst_flags got=%b exp=1100", {d_hs, d_vs, d_von, d_tick}); end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++; if (d_fc !== 16'd0) begin failures++; $display("FAIL mrst_frame_cnt got=%0d exp=0", d_fc); end
`endif
    endtask

    task automatic test_small_mode();
        int bad_pos = 0, bad_sync = 0, bad_von = 0, bad_ls = 0, bad_fc = 0, ls_cnt = 0, bad_fs = 0;
        int p, x, y;
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd41);
        reset = 1'b1;
        #1;
        checks++; if (s_tick !== 1'b1) begin failures++; $display("FAIL small_tick_c0 got=%b exp=1", s_tick); end
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            p = (k - 1) % 40;
            x = p % 8;
            y = p / 8;
            if (s_tick !== 1'b1 || s_x !== 10'(x) || s_y !== 10'(y)) bad_pos++;
            if (s_hs !== (x == 5 || x == 6) || s_vs !== (y != 3)) bad_sync++;
            if (s_von !== (x < 4 && y < 2)) bad_von++;
            if (s_ls !== (x == 0)) bad_ls++;
            if (s_ls === 1'b1) ls_cnt++;
            if (s_fs === 1'b1) begin
                if (exp_q.size() == 0 || exp_q.pop_front() !== 32'(k)) bad_fs++;
            end
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (s_fc !== 16'((k - 1) / 40 + 1)) bad_fc++;
`endif
        end
        checks++; if (bad_pos !== 0) begin failures++; $display("FAIL small_pos bad_samples=%0d exp=0", bad_pos); end
        checks++; if (bad_sync !== 0) begin failures++; $display("FAIL small_sync bad_samples=%0d exp=0", bad_sync); end
        checks++; if (bad_von !== 0) begin failures++; $display("FAIL small_video_on bad_samples=%0d exp=0", bad_von); end
        checks++; if (bad_ls !== 0 || ls_cnt !== 10) begin failures++; $display("FAIL small_line_start bad=%0d count=%0d exp 0,10", bad_ls, ls_cnt); end
        checks++; if (bad_fs !== 0 || exp_q.size() !== 0) begin failures++; $display("FAIL small_frame_start bad=%0d left=%0d exp 0,0", bad_fs, exp_q.size()); end
        checks++; if (bad_fc !== 0) begin failures++; $display("FAIL small_frame_cnt bad_samples=%0d exp=0", bad_fc); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_line();
        test_freeze();
        test_mid_reset();
        test_small_mode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
